// File: rtl/alu_unit.sv
// 16-function ALU with a single registered result stage.
// Operands are unsigned; results are zero-extended to 2*WIDTH bits.
module alu_unit #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         sel,
    output logic [2*WIDTH-1:0] y
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0] ae;
    logic [W2-1:0] be;
    logic [W2-1:0] res;
    logic          gt;
    logic          eq;
    logic          lt;

    assign ae = {{WIDTH{1'b0}}, a};
    assign be = {{WIDTH{1'b0}}, b};
    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

    always_comb begin
        res = '0;
        case (sel)
            4'd0:  res = ae + be;
            4'd1:  res = ae - be;
            4'd2:  res = ae * be;
            4'd3:  res = (b == '0) ? {W2{1'b1}} : ae / be;
            4'd4:  res = (b == '0) ? ae : ae % be;
            4'd5:  res = ae & be;
            4'd6:  res = ae | be;
            4'd7:  res = ae ^ be;
            4'd8:  res = {{WIDTH{1'b0}}, ~(a & b)};
            4'd9:  res = {{WIDTH{1'b0}}, ~(a | b)};
            4'd10: res = {{WIDTH{1'b0}}, ~(a ^ b)};
            4'd11: res = {{WIDTH{1'b0}}, ~a};
            4'd12: res = ae << 1;
            4'd13: res = ae >> 1;
            4'd14: res = {{(W2-3){1'b0}}, gt, eq, lt};
            4'd15: res = ae + W2'(1);
            // X/Z select in simulation lands here
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            y <= '0;
        else
            y <= res;
    end

endmodule

// File: tb/tb_alu_unit.sv
// Directed, table-driven bench for alu_unit (WIDTH=4).
// Expected values are hand-computed constants.
module tb_alu_unit;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
    logic [7:0] y;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] sweep_exp [16];
    logic [7:0] prev;

    alu_unit #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .sel (sel),
        .y   (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] exp);
        checks++;
        if (y !== exp) begin
            errors++;
            $display("FAIL %s: y=%h expected %h", name, y, exp);
        end
    endtask

    task automatic add(input string n, input logic r, input logic [3:0] va,
                       input logic [3:0] vb, input logic [3:0] vs,
                       input logic [7:0] ve);
        vec_t v;
        v.name = n;
        v.rst  = r;
        v.a    = va;
        v.b    = vb;
        v.sel  = vs;
        v.exp  = ve;
        vecs.push_back(v);
    endtask

    initial begin
        sweep_exp = '{8'h15, 8'hF9, 8'h62, 8'h00, 8'h07,
                      8'h06, 8'h0F, 8'h09, 8'h09, 8'h00,
                      8'h06, 8'h08, 8'h0E, 8'h03, 8'h01, 8'h08};

        add("ovf_add",  1'b0, 4'd15, 4'd15, 4'd0,  8'h1E);
        add("ovf_mul",  1'b0, 4'd15, 4'd15, 4'd2,  8'hE1);
        add("ovf_inc",  1'b0, 4'd15, 4'd15, 4'd15, 8'h10);
        add("ovf_shl",  1'b0, 4'd15, 4'd15, 4'd12, 8'h1E);
        add("ovf_cmp",  1'b0, 4'd15, 4'd15, 4'd14, 8'h02);
        add("div0",     1'b0, 4'd9,  4'd0,  4'd3,  8'hFF);
        add("mod0",     1'b0, 4'd9,  4'd0,  4'd4,  8'h09);
        add("sub0",     1'b0, 4'd9,  4'd0,  4'd1,  8'h09);
        add("lat_add",  1'b0, 4'd1,  4'd1,  4'd0,  8'h02);
        add("lat_xor",  1'b0, 4'd3,  4'd1,  4'd7,  8'h02);
        add("cmp_eq",   1'b0, 4'd5,  4'd5,  4'd14, 8'h02);
        add("cmp_lt",   1'b0, 4'd0,  4'd15, 4'd14, 8'h01);
        add("cmp_gt",   1'b0, 4'd15, 4'd0,  4'd14, 8'h04);
        add("sub_wrap", 1'b0, 4'd0,  4'd1,  4'd1,  8'hFF);
        add("rst_prio", 1'b1, 4'd15, 4'd15, 4'd2,  8'h00);
        add("div_norm", 1'b0, 4'd14, 4'd3,  4'd3,  8'h04);
        add("mod_norm", 1'b0, 4'd14, 4'd3,  4'd4,  8'h02);

        rst = 1'b1;
        a   = 4'd7;
        b   = 4'd14;
        sel = 4'd2;
        @(posedge clk);
        #1 check("reset", 8'h00);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 check("rst_release", 8'h62);

        // Two clocks per sel; rst pulses on the second clock of sel 8
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            sel = 4'(s);
            @(posedge clk);
            #1 check($sformatf("sweep_sel%0d", s), sweep_exp[s]);
            @(negedge clk);
            if (s == 8) rst = 1'b1;
            @(posedge clk);
            #1;
            if (s == 8) begin
                check("sweep_rst_mid", 8'h00);
            end else begin
                check($sformatf("sweep_hold%0d", s), sweep_exp[s]);
            end
            rst = 1'b0;
        end
        prev = sweep_exp[15];

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst;
            a   = vecs[i].a;
            b   = vecs[i].b;
            sel = vecs[i].sel;
            #1 check({vecs[i].name, "_pre"}, prev);
            @(posedge clk);
            #1 check(vecs[i].name, vecs[i].exp);
            prev = vecs[i].exp;
        end

        @(negedge clk);
        rst = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- 16-function arithmetic/logic unit with a registered result.
- Operands a and b are combined according to sel; the result is captured into y on the rising clock edge.
- Used as a standalone combinational datapath with a single output register stage, and as a bring-up block for the datapath library.

Parameters:
- WIDTH, 4, operand width in bits. y is 2*WIDTH bits wide. All values in this spec are for WIDTH=4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- sel  input  4  operation select
- y  output  2*WIDTH  registered result

Behaviour:
- Reset: at a posedge with rst=1, y <= 0. Reset has priority over computation. rst asserted mid-stream clears y on that edge regardless of sel, a or b.
- Latency: at a posedge with rst=0, y <= f(sel, a, b) using the input values present just before the edge. Latency is exactly 1 cycle. No handshake; a new operation can be issued every cycle.
- y holds its value between edges. Before the first clock edge, y is undefined.
- Width rule: unless stated otherwise, results are zero-extended to 2*WIDTH bits.
- Operation encoding (sel):
  - 0 ADD: a+b; carry appears in bit WIDTH.
  - 1 SUB: a-b computed modulo 2^(2*WIDTH); a<b gives a two's-complement wrap (7-14 = 8'hF9).
  - 2 MUL: a*b, full 2*WIDTH-bit product.
  - 3 DIV: a/b, truncating. If b==0, y = all ones (8'hFF).
  - 4 MOD: a%b. If b==0, y = zero-extended a.
  - 5 AND: a&b.
  - 6 OR: a|b.
  - 7 XOR: a^b.
  - 8 NAND: ~(a&b), WIDTH bits, zero-extended.
  - 9 NOR: ~(a|b), WIDTH bits, zero-extended.
  - 10 XNOR: ~(a^b), WIDTH bits, zero-extended.
  - 11 NOT: ~a, WIDTH bits, zero-extended.
  - 12 SHL: a<<1 into 2*WIDTH bits, so the MSB of a is kept in bit WIDTH.
  - 13 SHR: a>>1, logical.
  - 14 CMP: y = {zeros, gt, eq, lt}, where bit2 = a>b, bit1 = a==b, bit0 = a<b. Exactly one of the three bits is set.
  - 15 INC: a+1; 4'hF+1 = 8'h10.
- Unknown or unlisted sel values (X/Z in simulation) take the default branch: y <= 0.
- No internal state other than the y register.

Test Plan:
- Reset:
  - rst=1 for one edge with a=7, b=14, sel=2 -> y=8'h00.
  - Deassert rst -> next edge y=8'h62.
  - Re-assert rst mid-sweep -> y=8'h00 on that edge.
- Full sweep with a=4'b0111 (7), b=4'b1110 (14), sel=0..15, changing sel every 2 clocks. Expected y, checked one edge after each sel change:
  - sel 0-4: 0x15, 0xF9, 0x62, 0x00, 0x07
  - sel 5-9: 0x06, 0x0F, 0x09, 0x09, 0x00
  - sel 10-15: 0x06, 0x08, 0x0E, 0x03, 0x01, 0x08
- Overflow/extension with a=15, b=15:
  - ADD -> 0x1E
  - MUL -> 0xE1
  - INC -> 0x10
  - SHL -> 0x1E
  - CMP -> 0x02
- Divide by zero with a=9, b=0:
  - DIV -> 0xFF
  - MOD -> 0x09
  - SUB -> 0x09
- Latency check: change sel and a together between edges (sel=0, a=1, b=1, then sel=7, a=3) -> y shows 0x02 after the first edge and 0x02 (3^1) after the next. There is never a combinational change of y between edges.
- Compare corners:
  - a=b=5 -> 0x02
  - a=0, b=15 -> 0x01
  - a=15, b=0 -> 0x04
  - SUB with a=0, b=1 -> 0xFF
